// File: rtl/seq_burst_arbiter_pkg.sv
// rtl/seq_burst_arbiter_pkg.sv - shared types, defaults and reset pattern for the burst arbiter
package seq_burst_arbiter_pkg;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_WIDTH   = 8;
  localparam int LEN_W       = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  localparam logic [7:0] DEFAULT_PATTERN [8] = '{
    8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
  };

endpackage

// File: rtl/seq_burst_arbiter_if.sv
// rtl/seq_burst_arbiter_if.sv - request/grant and pattern stream bundle
interface seq_burst_arbiter_if
  import seq_burst_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
) ();

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic                     out_last;

  modport master (
    output req, req_len, out_ready,
    input  grant, done, out_valid, out_data, out_last
  );

  modport slave (
    input  req, req_len, out_ready,
    output grant, done, out_valid, out_data, out_last
  );

endinterface

// File: rtl/seq_burst_arbiter_rr_arbiter.sv
// rtl/seq_burst_arbiter_rr_arbiter.sv - round-robin pick; search starts just after the last winner
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = PW + 1;

  logic [PW-1:0] start_q, start_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= '0;
    end else begin
      start_q <= start_d;
    end
  end

  always_comb begin
    logic [SW-1:0] sum;
    logic [PW-1:0] idx;
    logic          found;
    grant   = '0;
    start_d = start_q;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, start_q} + SW'(i);
      if (sum >= SW'(NUM_REQ)) begin
        sum = sum - SW'(NUM_REQ);
      end
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        if (advance) begin
          start_d = (idx == PW'(NUM_REQ - 1)) ? '0 : idx + PW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/seq_burst_arbiter.sv
// rtl/seq_burst_arbiter.sv - grants bursts round-robin and streams bytes from a shared pattern table
module seq_burst_arbiter
  import seq_burst_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_addr,
  input  logic [WIDTH-1:0]   cfg_wdata,
  output logic               cfg_busy,
  seq_burst_arbiter_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e             state_q, state_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]   beats_q, beats_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] arb_grant;
  logic [LEN_W-1:0]   len_sel;
  logic               arb_advance;
  logic [WIDTH-1:0]   table_q [DEPTH];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus.req),
    .advance (arb_advance),
    .grant   (arb_grant)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      beats_q  <= '0;
      owner_q  <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      beats_q  <= beats_d;
      owner_q  <= owner_d;
      done_q   <= done_d;
    end
  end

  // Table is frozen while streaming so out_data holds across stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= WIDTH'(DEFAULT_PATTERN[i[2:0]]);
      end
    end else if (cfg_we && state_q == ST_IDLE) begin
      table_q[cfg_addr] <= cfg_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    beats_d     = beats_q;
    owner_d     = owner_q;
    done_d      = '0;
    arb_advance = 1'b0;
    len_sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        len_sel = bus.req_len[i*LEN_W +: LEN_W];
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          arb_advance = 1'b1;
          owner_d     = arb_grant;
          beats_d     = len_sel;
          state_d     = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (bus.out_ready) begin
          rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
          if (beats_q == '0) begin
            state_d = ST_IDLE;
            owner_d = '0;
            done_d  = owner_q;
          end else begin
            beats_d = beats_q - LEN_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cfg_busy      = (state_q == ST_STREAM);
  assign bus.out_valid = (state_q == ST_STREAM);
  assign bus.grant     = owner_q;
  assign bus.done      = done_q;
  assign bus.out_last  = (state_q == ST_STREAM) && (beats_q == '0);
  assign bus.out_data  = (state_q == ST_STREAM) ? table_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_seq_burst_arbiter.sv
// tb/tb_seq_burst_arbiter.sv - vector table, reset corner case and randomized model check of seq_burst_arbiter
module tb_seq_burst_arbiter;

  localparam int N = 2;
  localparam logic [7:0] PATTERN [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       cfg_busy;

  int n_checks = 0;
  int n_fail   = 0;

  seq_burst_arbiter_if #(.NUM_REQ(N), .WIDTH(8)) bus ();

  seq_burst_arbiter #(.NUM_REQ(N), .DEPTH(8), .WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_busy  (cfg_busy),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [1:0] req;
    logic [2:0] l0;
    logic [2:0] l1;
    logic       rdy;
    logic       we;
    logic [2:0] addr;
    logic [7:0] wd;
    logic       busy;
    logic       last;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[$];
  vec_t v;

  // Reference model state: a burst is a queue of the bytes it will deliver.
  logic       m_busy;
  logic [7:0] m_q[$];
  logic [7:0] m_tab [8];
  int         m_owner, m_done, m_ptr, m_rr;
  logic [14:0] m_exp;

  function automatic void mk(int rst, int req, int l0, int l1, int rdy, int we, int a, int wd,
                             int busy, int last, int gnt, int done, int data);
    vec_t r;
    r.rst = rst[0]; r.req = req[1:0]; r.l0 = l0[2:0]; r.l1 = l1[2:0];
    r.rdy = rdy[0]; r.we = we[0]; r.addr = a[2:0]; r.wd = wd[7:0];
    r.busy = busy[0]; r.last = last[0]; r.gnt = gnt[1:0]; r.done = done[1:0]; r.data = data[7:0];
    vecs.push_back(r);
  endfunction

  function automatic logic [14:0] outs();
    return {cfg_busy, bus.out_valid, bus.out_last, bus.grant, bus.done, bus.out_data};
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: {busy,valid,last,grant,done,data} got %b_%b_%b_%b_%b_%h required %b_%b_%b_%b_%b_%h",
               name, act[14], act[13], act[12], act[11:10], act[9:8], act[7:0],
               exp[14], exp[13], exp[12], exp[11:10], exp[9:8], exp[7:0]);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [2:0] l0, input logic [2:0] l1,
                       input logic rdy, input logic we, input logic [2:0] a, input logic [7:0] wd);
    bus.req       = r;
    bus.req_len   = {l1, l0};
    bus.out_ready = rdy;
    cfg_we        = we;
    cfg_addr      = a;
    cfg_wdata     = wd;
  endtask

  task automatic do_reset();
    drive(2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 8'h00);
    #1 reset_n = 1'b0;
    #1 check("reset_state", outs(), 15'h0);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic model_init();
    m_busy = 1'b0;
    m_q.delete();
    m_done = -1;
    m_ptr  = 0;
    m_rr   = 0;
    for (int i = 0; i < 8; i++) m_tab[i] = PATTERN[i];
  endtask

  task automatic model_expect();
    logic [1:0] g, d;
    logic [7:0] dat;
    g   = m_busy ? 2'(1 << m_owner) : 2'b00;
    d   = (m_done >= 0) ? 2'(1 << m_done) : 2'b00;
    dat = m_busy ? m_q[0] : 8'h00;
    m_exp = {m_busy, m_busy, m_busy && (m_q.size() == 1), g, d, dat};
  endtask

  task automatic model_step();
    int len;
    int idx;
    m_done = -1;
    if (m_busy) begin
      if (bus.out_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_busy = 1'b0;
          m_done = m_owner;
        end
      end
    end else begin
      if (cfg_we) m_tab[cfg_addr] = cfg_wdata;
      if (bus.req != 2'b00) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (bus.req[idx]) begin
            m_owner = idx;
            break;
          end
        end
        m_rr = (m_owner + 1) % N;
        len  = (m_owner == 0) ? int'(bus.req_len[2:0]) : int'(bus.req_len[5:3]);
        for (int b = 0; b <= len; b++) m_q.push_back(m_tab[(m_ptr + b) % 8]);
        m_ptr  = (m_ptr + len + 1) % 8;
        m_busy = 1'b1;
      end
    end
  endtask

  initial begin
    reset_n = 1'b1;
    drive(2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 8'h00);

    //  rst req   l0 l1 rdy we a wd      busy last gnt   done  data
    // single 3-beat burst after reset
    mk(1, 'b01, 2, 0, 1, 0, 0, 'h00,   0, 0, 'b00, 'b00, 'h00);
    mk(0, 'b00, 2, 0, 1, 0, 0, 'h00,   1, 0, 'b01, 'b00, 'hAF);
    mk(0, 'b00, 2, 0, 1, 0, 0, 'h00,   1, 0, 'b01, 'b00, 'hBC);
    mk(0, 'b00, 2, 0, 1, 0, 0, 'h00,   1, 1, 'b01, 'b00, 'hE2);
    mk(0, 'b00, 2, 0, 1, 0, 0, 'h00,   0, 0, 'b00, 'b01, 'h00);
    // both requesters held, single beats alternate with one idle gap
    mk(1, 'b11, 0, 0, 1, 0, 0, 'h00,   0, 0, 'b00, 'b00, 'h00);
    mk(0, 'b11, 0, 0, 1, 0, 0, 'h00,   1, 1, 'b01, 'b00, 'hAF);
    mk(0, 'b11, 0, 0, 1, 0, 0, 'h00,   0, 0, 'b00, 'b01, 'h00);
    mk(0, 'b11, 0, 0, 1, 0, 0, 'h00,   1, 1, 'b10, 'b00, 'hBC);
    mk(0, 'b11, 0, 0, 1, 0, 0, 'h00,   0, 0, 'b00, 'b10, 'h00);
    mk(0, 'b00, 0, 0, 1, 0, 0, 'h00,   1, 1, 'b01, 'b00, 'hE2);
    mk(0, 'b00, 0, 0, 1, 0, 0, 'h00,   0, 0, 'b00, 'b01, 'h00);
    // advance pointer to 6, then a 4-beat burst wraps through index 0
    mk(0, 'b10, 0, 2, 1, 0, 0, 'h00,   0, 0, 'b00, 'b00, 'h00);
    mk(0, 'b00, 0, 2, 1, 0, 0, 'h00,   1, 0, 'b10, 'b00, 'h78);
    mk(0, 'b00, 0, 2, 1, 0, 0, 'h00,   1, 0, 'b10, 'b00, 'hFF);
    mk(0, 'b00, 0, 2, 1, 0, 0, 'h00,   1, 1, 'b10, 'b00, 'hE2);
    mk(0, 'b01, 3, 0, 1, 0, 0, 'h00,   0, 0, 'b00, 'b10, 'h00);
    mk(0, 'b00, 3, 0, 1, 0, 0, 'h00,   1, 0, 'b01, 'b00, 'h0B);
    mk(0, 'b00, 3, 0, 1, 0, 0, 'h00,   1, 0, 'b01, 'b00, 'h8D);
    mk(0, 'b00, 3, 0, 1, 0, 0, 'h00,   1, 0, 'b01, 'b00, 'hAF);
    mk(0, 'b00, 3, 0, 1, 0, 0, 'h00,   1, 1, 'b01, 'b00, 'hBC);
    mk(0, 'b00, 3, 0, 1, 0, 0, 'h00,   0, 0, 'b00, 'b01, 'h00);
    // out_ready stalls mid-burst and on the last beat
    mk(0, 'b10, 0, 3, 1, 0, 0, 'h00,   0, 0, 'b00, 'b00, 'h00);
    mk(0, 'b00, 0, 3, 1, 0, 0, 'h00,   1, 0, 'b10, 'b00, 'hE2);
    mk(0, 'b00, 0, 3, 0, 0, 0, 'h00,   1, 0, 'b10, 'b00, 'h78);
    mk(0, 'b00, 0, 3, 0, 0, 0, 'h00,   1, 0, 'b10, 'b00, 'h78);
    mk(0, 'b00, 0, 3, 1, 0, 0, 'h00,   1, 0, 'b10, 'b00, 'h78);
    mk(0, 'b00, 0, 3, 1, 0, 0, 'h00,   1, 0, 'b10, 'b00, 'hFF);
    mk(0, 'b00, 0, 3, 0, 0, 0, 'h00,   1, 1, 'b10, 'b00, 'hE2);
    mk(0, 'b00, 0, 3, 1, 0, 0, 'h00,   1, 1, 'b10, 'b00, 'hE2);
    mk(0, 'b00, 0, 3, 1, 0, 0, 'h00,   0, 0, 'b00, 'b10, 'h00);
    // table write while streaming is dropped; write plus grant in idle lands
    mk(0, 'b01, 2, 0, 1, 0, 0, 'h00,   0, 0, 'b00, 'b00, 'h00);
    mk(0, 'b00, 2, 0, 1, 1, 0, 'h55,   1, 0, 'b01, 'b00, 'h0B);
    mk(0, 'b00, 2, 0, 1, 0, 0, 'h00,   1, 0, 'b01, 'b00, 'h8D);
    mk(0, 'b00, 2, 0, 1, 0, 0, 'h00,   1, 1, 'b01, 'b00, 'hAF);
    mk(0, 'b00, 2, 0, 1, 0, 0, 'h00,   0, 0, 'b00, 'b01, 'h00);
    mk(1, 'b01, 0, 0, 1, 1, 0, 'h55,   0, 0, 'b00, 'b00, 'h00);
    mk(0, 'b00, 0, 0, 1, 0, 0, 'h00,   1, 1, 'b01, 'b00, 'h55);
    mk(0, 'b00, 0, 0, 1, 0, 0, 'h00,   0, 0, 'b00, 'b01, 'h00);
    // maximum length; req drop and req_len change mid-burst have no effect
    mk(0, 'b10, 0, 7, 1, 0, 0, 'h00,   0, 0, 'b00, 'b00, 'h00);
    mk(0, 'b00, 0, 0, 1, 0, 0, 'h00,   1, 0, 'b10, 'b00, 'hBC);
    mk(0, 'b00, 0, 0, 1, 0, 0, 'h00,   1, 0, 'b10, 'b00, 'hE2);
    mk(0, 'b00, 0, 0, 1, 0, 0, 'h00,   1, 0, 'b10, 'b00, 'h78);
    mk(0, 'b00, 0, 0, 1, 0, 0, 'h00,   1, 0, 'b10, 'b00, 'hFF);
    mk(0, 'b00, 0, 0, 1, 0, 0, 'h00,   1, 0, 'b10, 'b00, 'hE2);
    mk(0, 'b00, 0, 0, 1, 0, 0, 'h00,   1, 0, 'b10, 'b00, 'h0B);
    mk(0, 'b00, 0, 0, 1, 0, 0, 'h00,   1, 0, 'b10, 'b00, 'h8D);
    mk(0, 'b00, 0, 0, 1, 0, 0, 'h00,   1, 1, 'b10, 'b00, 'h55);
    mk(0, 'b00, 0, 0, 1, 0, 0, 'h00,   0, 0, 'b00, 'b10, 'h00);

    #1;
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      if (v.rst) do_reset();
      @(posedge clk);
      #1 drive(v.req, v.l0, v.l1, v.rdy, v.we, v.addr, v.wd);
      @(negedge clk);
      check($sformatf("vec%0d", k), outs(), {v.busy, v.busy, v.last, v.gnt, v.done, v.data});
    end

    // reset pulse mid-burst, no clock edge while low
    @(posedge clk);
    #1 drive(2'b01, 3'd3, 3'd0, 1'b1, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    check("mid_rst_idle", outs(), 15'h0);
    @(posedge clk);
    #1 drive(2'b00, 3'd3, 3'd0, 1'b1, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    check("mid_rst_beat0", outs(), {1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 8'hBC});
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_beat1", outs(), {1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 8'hE2});
    #1 reset_n = 1'b0;
    #1 check("mid_rst_async_clear", outs(), 15'h0);
    #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_no_done", outs(), 15'h0);
    @(posedge clk);
    #1 drive(2'b01, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    check("mid_rst_idle2", outs(), 15'h0);
    @(posedge clk);
    #1 drive(2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    check("mid_rst_restart", outs(), {1'b1, 1'b1, 1'b1, 2'b01, 2'b00, 8'hAF});

    // randomized traffic against the burst-queue model
    do_reset();
    model_init();
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1 drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
               3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      @(negedge clk);
      model_expect();
      check($sformatf("rand%0d", c), outs(), m_exp);
      model_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_burst_arbiter.md
SEQ_BURST_ARBITER -- requirements
Module: seq_burst_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 2, number of requesters; DEPTH, default 8, pattern table entries; WIDTH, default 8, data width.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 cfg_we  in  1  pattern table write strobe.
REQ-005 cfg_addr  in  3  table write index.
REQ-006 cfg_wdata  in  WIDTH  table write data.
REQ-007 cfg_busy  out  1  high while a burst is active; writes ignored.
REQ-008 req  in  NUM_REQ  level burst request, one bit per requester.
REQ-009 req_len  in  NUM_REQ*3  per-requester burst length minus one (0..7 gives 1..8 beats).
REQ-010 grant  out  NUM_REQ  one-hot owner of the current burst.
REQ-011 done  out  NUM_REQ  one-cycle pulse to the owner after its last beat is accepted.
REQ-012 out_valid / out_ready / out_data[WIDTH] / out_last  valid-ready stream of pattern bytes.

Function
REQ-013 FSM SHALL have two states: IDLE and STREAM.
REQ-014 In IDLE with any req bit high, the block SHALL grant round-robin starting after the last grantee (requester 0 first after reset), latch that requester's req_len, and enter STREAM at the next edge.
REQ-015 grant, out_valid and cfg_busy SHALL assert in the cycle after the request is sampled (latency 1) and stay high throughout STREAM.
REQ-016 out_data SHALL equal table[rd_ptr] whenever out_valid is high, and SHALL hold stable until out_ready is sampled high.
REQ-017 Each accepted beat SHALL increment rd_ptr modulo DEPTH (7 -> 0) and decrement the beat counter; rd_ptr is shared and persists across bursts.
REQ-018 out_last SHALL be high on the final beat; on its acceptance the FSM SHALL return to IDLE, pulse done for the owner for one cycle, and deassert grant/out_valid/cfg_busy.
REQ-019 There SHALL be a minimum of one IDLE cycle between bursts; back-to-back requests are re-arbitrated in that cycle.
REQ-020 Deassertion of req mid-burst SHALL NOT shorten the burst; req_len changes after grant SHALL be ignored.
REQ-021 cfg_we SHALL write table[cfg_addr] only in IDLE; in STREAM it is dropped silently.
REQ-022 A write and a grant in the same IDLE cycle SHALL both take effect; the first beat reflects the new table contents.
REQ-023 out_ready low SHALL stall all state with no beat lost or duplicated.

Reset
REQ-024 On reset_n low, immediately and asynchronously: state=IDLE, rd_ptr=0, round-robin pointer=requester 0, grant=0, done=0, out_valid=0, out_last=0, cfg_busy=0, out_data=0.
REQ-025 Reset SHALL load the table with AF, BC, E2, 78, FF, E2, 0B, 8D (indices 0..7).
REQ-026 Reset asserted mid-burst SHALL abort it with no done pulse.

Structure
REQ-027 A shared package SHALL hold the state enumeration, the WIDTH/DEPTH defaults and the default pattern constant array.
REQ-028 The round-robin arbiter SHALL be one sub-module, rr_arbiter (req, advance, one-hot grant).

Verification
REQ-029 Scenario: after reset, req=01, len0=2, out_ready=1 -> beats AF, BC, E2 on consecutive cycles; out_last on E2; done=01 the following cycle.
REQ-030 Scenario: req=11 held, both lengths 0 -> grants alternate 01, 10, 01; data AF, BC, E2; one IDLE cycle between bursts.
REQ-031 Scenario: rd_ptr=6, burst length 4 -> 0B, 8D, AF, BC; pointer wraps to 0.
REQ-032 Scenario: out_ready toggles 1,0,0,1 mid-burst -> out_data holds during the stall; no beat is skipped.
REQ-033 Scenario: cfg_we at addr 0 with 55 during STREAM -> ignored; same write in IDLE with a simultaneous req -> first beat 55.
REQ-034 Scenario: reset_n pulsed low mid-burst -> outputs clear without a clock edge; no done pulse; next burst starts at AF.
